// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 8-line round-robin request arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int PTR_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate pend so ptr sits at bit 0, take the
// lowest set bit, then rotate the winning index back into absolute position.
module rr_pick #(
  parameter int N_REQ = 8,
  parameter int PTR_W = 3
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] sel,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [PTR_W-1:0] off;

  // N_REQ is a power of two, so the PTR_W-bit sum wraps exactly modulo N_REQ.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot[gi] = pend[ptr + PTR_W'(gi)];
    end
  endgenerate

  always_comb begin
    off = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off = PTR_W'(j);
      end
    end
  end

  assign any = |rot;
  assign idx = off + ptr;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sel
      assign sel[gi] = any && (idx == PTR_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/req_arbiter8.sv
// Round-robin request arbiter feeding an 8-to-3 encoder: latches request pulses,
// issues one registered one-hot grant at a time and holds it until ack.
module req_arbiter8 #(
  parameter int N_REQ = arb_pkg::N_REQ,
  parameter int PTR_W = arb_pkg::PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  input  logic             ack,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [N_REQ-1:0] pend
);

  import arb_pkg::state_t;
  import arb_pkg::ST_IDLE;
  import arb_pkg::ST_GRANT;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [N_REQ-1:0] clr;

  logic [N_REQ-1:0] sel_onehot;
  logic [PTR_W-1:0] sel_idx;
  logic             sel_any;

  rr_pick #(
    .N_REQ(N_REQ),
    .PTR_W(PTR_W)
  ) u_pick (
    .pend(pend_q),
    .ptr (ptr_q),
    .sel (sel_onehot),
    .idx (sel_idx),
    .any (sel_any)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    clr         = '0;
    case (state_q)
      ST_IDLE: begin
        if (en && sel_any) begin
          gnt_d       = sel_onehot;
          gnt_valid_d = 1'b1;
          gidx_d      = sel_idx;
          state_d     = ST_GRANT;
        end else begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (ack) begin
          clr         = gnt_q;
          ptr_d       = gidx_q + PTR_W'(1);
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    // A new request on the acked line re-arms it: set beats clear.
    pend_d = (pend_q & ~clr) | req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
      gidx_q      <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign pend      = pend_q;

endmodule
